// File: rtl/ram_subquad_ctrl_if.sv
// ---------------------------------------------------------------------------
// ram_subquad_pkg / ram_subquad_ctrl_if
//
// Purpose : shared access-size type and the requester-side bus of the
//           sub-quad RAM controller (request handshake plus completion).
//
// Ports (interface signals):
//   req_valid   requester -> ctrl  request present
//   req_ready   ctrl -> requester  controller idle; transfer on valid&&ready
//   req_write   requester -> ctrl  1 = store, 0 = load
//   req_addr    requester -> ctrl  byte address
//   req_type    requester -> ctrl  access size (quad/long/word/byte)
//   req_wdata   requester -> ctrl  store data, right-justified
//   resp_valid  ctrl -> requester  one-cycle completion pulse
//   resp_err    ctrl -> requester  misaligned request, nothing accessed
//   resp_rdata  ctrl -> requester  load data, zero-extended
// ---------------------------------------------------------------------------
package ram_subquad_pkg;

    typedef enum logic [1:0] {
        RAM_QUAD = 2'd0,
        RAM_LONG = 2'd1,
        RAM_WORD = 2'd2,
        RAM_BYTE = 2'd3
    } data_type_t;

endpackage

interface ram_subquad_ctrl_if #(
    parameter int ADDR_WIDTH = 16
);
    import ram_subquad_pkg::*;

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_WIDTH-1:0] req_addr;
    data_type_t            req_type;
    logic [63:0]           req_wdata;
    logic                  resp_valid;
    logic                  resp_err;
    logic [63:0]           resp_rdata;

    // Requester side (loader / CPU memory stage).
    modport master (
        output req_valid, req_write, req_addr, req_type, req_wdata,
        input  req_ready, resp_valid, resp_err, resp_rdata
    );

    // Controller side.
    modport slave (
        input  req_valid, req_write, req_addr, req_type, req_wdata,
        output req_ready, resp_valid, resp_err, resp_rdata
    );

endinterface

// File: rtl/ram_subquad_ctrl.sv
// ---------------------------------------------------------------------------
// ram_subquad_ctrl
//
// Purpose : sequences byte/word/long/quad loads and stores from a single
//           requester onto a 64-bit, big-endian, quad-wide RAM port.
//           Loads are returned zero-extended; sub-quad stores are done as
//           read-modify-write of the containing quad. Misaligned requests
//           complete with an error and never touch the RAM.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   bus        requester interface (slave modport): req_* / resp_*
//   ram_en     RAM access this cycle
//   ram_we     write when ram_en
//   ram_addr   quad index (byte address bits [ADDR_WIDTH-1:3]), 0 when idle
//   ram_wdata  write quad, 0 when idle
//   ram_rdata  read quad, valid the cycle after a read-enable cycle
// ---------------------------------------------------------------------------
module ram_subquad_ctrl
    import ram_subquad_pkg::*;
#(
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    ram_subquad_ctrl_if.slave     bus,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-4:0] ram_addr,
    output logic [63:0]           ram_wdata,
    input  logic [63:0]           ram_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WT,
        WR,
        RESP
    } state_t;

    state_t                state;

    // Request fields captured on accept.
    logic                  write_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    data_type_t            type_q;
    logic [63:0]           wdata_q;

    // -----------------------------------------------------------------------
    // Alignment of the incoming request (evaluated only in IDLE).
    // -----------------------------------------------------------------------
    logic misaligned;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        misaligned = 1'b0;
        case (bus.req_type)
            RAM_QUAD: misaligned = (bus.req_addr[2:0] != 3'b000);
            RAM_LONG: misaligned = (bus.req_addr[1:0] != 2'b00);
            RAM_WORD: misaligned = bus.req_addr[0];
            RAM_BYTE: misaligned = 1'b0;
        endcase
    end

    // -----------------------------------------------------------------------
    // Lane geometry of the registered request.
    // Big-endian: the lane of an aligned access at offset o with n bytes
    // sits 8*(8-o-n) bits above bit 0. Because the access is aligned,
    // (8-o-n) equals ~o with the offset bits that lie inside the access
    // cleared, so the shift is {~o & offset_mask, 3'b000}.
    // -----------------------------------------------------------------------
    logic [2:0]  offset_mask;
    logic [63:0] size_mask;
    logic [5:0]  lane_shift;
    logic [63:0] lane_mask;
    logic [63:0] load_lane;
    logic [63:0] merged_quad;

    always_comb begin
        offset_mask = 3'b000;
        size_mask   = '1;
        case (type_q)
            RAM_BYTE: begin
                offset_mask = 3'b111;
                size_mask   = 64'h0000_0000_0000_00FF;
            end
            RAM_WORD: begin
                offset_mask = 3'b110;
                size_mask   = 64'h0000_0000_0000_FFFF;
            end
            RAM_LONG: begin
                offset_mask = 3'b100;
                size_mask   = 64'h0000_0000_FFFF_FFFF;
            end
            RAM_QUAD: begin
                offset_mask = 3'b000;
                size_mask   = '1;
            end
        endcase
        lane_shift  = {~addr_q[2:0] & offset_mask, 3'b000};
        lane_mask   = size_mask << lane_shift;
        load_lane   = (ram_rdata >> lane_shift) & size_mask;
        merged_quad = (ram_rdata & ~lane_mask) | ((wdata_q & size_mask) << lane_shift);
    end

    // -----------------------------------------------------------------------
    // Control FSM. All outputs are registered: each transition loads the
    // output values of the state being entered, and every output falls back
    // to 0 (req_ready included) unless the target state drives it.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            write_q        <= 1'b0;
            addr_q         <= '0;
            type_q         <= RAM_QUAD;
            wdata_q        <= '0;
            bus.req_ready  <= 1'b1;
            bus.resp_valid <= 1'b0;
            bus.resp_err   <= 1'b0;
            bus.resp_rdata <= '0;
            ram_en         <= 1'b0;
            ram_we         <= 1'b0;
            ram_addr       <= '0;
            ram_wdata      <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order;
            // the defaults below are overridden later in the same block.
            bus.req_ready  <= 1'b0;
            bus.resp_valid <= 1'b0;
            bus.resp_err   <= 1'b0;
            bus.resp_rdata <= '0;
            ram_en         <= 1'b0;
            ram_we         <= 1'b0;
            ram_addr       <= '0;
            ram_wdata      <= '0;

            case (state)
                IDLE: begin
                    // req_ready is 1 only here, so req_valid alone is accept.
                    if (bus.req_valid) begin
                        write_q <= bus.req_write;
                        addr_q  <= bus.req_addr;
                        type_q  <= bus.req_type;
                        wdata_q <= bus.req_wdata;
                        if (misaligned) begin
                            state          <= RESP;
                            bus.resp_valid <= 1'b1;
                            bus.resp_err   <= 1'b1;
                        end else if (bus.req_write && bus.req_type == RAM_QUAD) begin
                            // Full-quad store needs no read: write directly.
                            state     <= WR;
                            ram_en    <= 1'b1;
                            ram_we    <= 1'b1;
                            ram_addr  <= bus.req_addr[ADDR_WIDTH-1:3];
                            ram_wdata <= bus.req_wdata;
                        end else begin
                            state    <= RD;
                            ram_en   <= 1'b1;
                            ram_addr <= bus.req_addr[ADDR_WIDTH-1:3];
                        end
                    end else begin
                        bus.req_ready <= 1'b1;
                    end
                end

                RD: begin
                    // Read issued this cycle; data arrives in WT.
                    state <= WT;
                end

                WT: begin
                    if (write_q) begin
                        state     <= WR;
                        ram_en    <= 1'b1;
                        ram_we    <= 1'b1;
                        ram_addr  <= addr_q[ADDR_WIDTH-1:3];
                        ram_wdata <= merged_quad;
                    end else begin
                        state          <= RESP;
                        bus.resp_valid <= 1'b1;
                        bus.resp_rdata <= load_lane;
                    end
                end

                WR: begin
                    state          <= RESP;
                    bus.resp_valid <= 1'b1;
                end

                RESP: begin
                    state         <= IDLE;
                    bus.req_ready <= 1'b1;
                end

                default: begin
                    state         <= IDLE;
                    bus.req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_subquad_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ram_subquad_ctrl
//
// Directed bench for ram_subquad_ctrl: a behavioural quad RAM with one-cycle
// read latency, a table of single requests with hand-computed results, and
// hand-written sequences for reset-during-RMW and back-to-back requests.
// ---------------------------------------------------------------------------
module tb_ram_subquad_ctrl;
    import ram_subquad_pkg::*;

    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ram_en;
    logic          ram_we;
    logic [AW-4:0] ram_addr;
    logic [63:0]   ram_wdata;
    logic [63:0]   ram_rdata = '0;

    logic [63:0]   mem [0:(1 << (AW-3)) - 1];

    int n_cmp  = 0;
    int n_fail = 0;
    int we_cnt = 0;
    int resp_cnt = 0;

    ram_subquad_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

    ram_subquad_ctrl #(.ADDR_WIDTH(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    always #5 clk = ~clk;

    // Quad RAM: registered read, data valid the cycle after the enable.
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata     <= mem[ram_addr];
        end
    end

    // Event counters sampled mid-cycle.
    always @(negedge clk) begin
        if (ram_en && ram_we) we_cnt++;
        if (bus.resp_valid)   resp_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, required finish before 500000");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    // Issue one request; caller must be mid-cycle with the DUT idle.
    // Latency counts cycles after the accept edge (first cycle = 1).
    task automatic do_req(input logic wr, input logic [15:0] a, input data_type_t t,
                          input logic [63:0] wd,
                          output int lat, output logic err, output logic [63:0] rdata,
                          output int rc, output int wl, output logic [12:0] wa,
                          output logic [63:0] wdq);
        check("req_ready_before_accept", 64'(bus.req_ready), 64'd1);
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = a;
        bus.req_type  = t;
        bus.req_wdata = wd;
        @(posedge clk);
        lat = 0; err = 1'b0; rdata = '0; rc = 0; wl = 0; wa = '0; wdq = '0;
        while (lat < 12) begin
            @(negedge clk);
            bus.req_valid = 1'b0;
            lat++;
            if (ram_en) rc++;
            if (ram_en && ram_we) begin
                wl  = lat;
                wa  = ram_addr;
                wdq = ram_wdata;
            end
            if (bus.resp_valid) begin
                err   = bus.resp_err;
                rdata = bus.resp_rdata;
                break;
            end
        end
    endtask

    typedef struct {
        logic        write;
        logic [15:0] addr;
        data_type_t  dtype;
        logic [63:0] wdata;
        logic        exp_err;
        logic [63:0] exp_rdata;
        int          exp_lat;
        int          exp_ram_cycles;
        int          exp_wr_lat;    // 0 = no write expected
        int          chk_idx;       // -1 = no RAM content check
        logic [63:0] exp_quad;
    } vec_t;

    vec_t vecs [12];

    initial begin
        int          lat, rc, wl;
        logic        err;
        logic [63:0] rdata, wdq;
        logic [12:0] wa;
        int          we_snap, resp_snap;

        vecs[0]  = '{1'b0, 16'h0003, RAM_BYTE, 64'h0, 1'b0, 64'h0000_0000_0000_0033, 3, 1, 0, -1, 64'h0};
        vecs[1]  = '{1'b0, 16'h0006, RAM_WORD, 64'h0, 1'b0, 64'h0000_0000_0000_6677, 3, 1, 0, -1, 64'h0};
        vecs[2]  = '{1'b0, 16'h0000, RAM_LONG, 64'h0, 1'b0, 64'h0000_0000_0011_2233, 3, 1, 0, -1, 64'h0};
        vecs[3]  = '{1'b0, 16'h0000, RAM_QUAD, 64'h0, 1'b0, 64'h0011_2233_4455_6677, 3, 1, 0, -1, 64'h0};
        vecs[4]  = '{1'b1, 16'h0001, RAM_BYTE, 64'hFFFF_FFFF_FFFF_FFAB, 1'b0, 64'h0, 4, 2, 3, 0, 64'h00AB_2233_4455_6677};
        vecs[5]  = '{1'b1, 16'h0008, RAM_QUAD, 64'h0123_4567_89AB_CDEF, 1'b0, 64'h0, 2, 1, 1, 1, 64'h0123_4567_89AB_CDEF};
        vecs[6]  = '{1'b0, 16'h0005, RAM_WORD, 64'h0, 1'b1, 64'h0, 1, 0, 0, -1, 64'h0};
        vecs[7]  = '{1'b1, 16'h0002, RAM_LONG, 64'hFFFF_FFFF, 1'b1, 64'h0, 1, 0, 0, 0, 64'h00AB_2233_4455_6677};
        vecs[8]  = '{1'b1, 16'h000E, RAM_WORD, 64'hFFFF_FFFF_FFFF_1234, 1'b0, 64'h0, 4, 2, 3, 1, 64'h0123_4567_89AB_1234};
        vecs[9]  = '{1'b0, 16'h000F, RAM_BYTE, 64'h0, 1'b0, 64'h0000_0000_0000_0034, 3, 1, 0, -1, 64'h0};
        vecs[10] = '{1'b0, 16'h0009, RAM_QUAD, 64'h0, 1'b1, 64'h0, 1, 0, 0, -1, 64'h0};
        vecs[11] = '{1'b1, 16'h0007, RAM_BYTE, 64'h5A, 1'b0, 64'h0, 4, 2, 3, 0, 64'h00AB_2233_4455_665A};

        mem[0] = 64'h0011_2233_4455_6677;
        mem[1] = 64'h0;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_type  = RAM_QUAD;
        bus.req_wdata = '0;

        // Reset state.
        #12;
        check("rst_req_ready",  64'(bus.req_ready),  64'd1);
        check("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        check("rst_resp_err",   64'(bus.resp_err),   64'd0);
        check("rst_resp_rdata", bus.resp_rdata,      64'd0);
        check("rst_ram_en",     64'(ram_en),         64'd0);
        check("rst_ram_we",     64'(ram_we),         64'd0);
        check("rst_ram_addr",   64'(ram_addr),       64'd0);
        check("rst_ram_wdata",  ram_wdata,           64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Table of single requests.
        for (int i = 0; i < 12; i++) begin
            do_req(vecs[i].write, vecs[i].addr, vecs[i].dtype, vecs[i].wdata,
                   lat, err, rdata, rc, wl, wa, wdq);
            check($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].exp_lat));
            check($sformatf("v%0d_err", i), 64'(err), 64'(vecs[i].exp_err));
            check($sformatf("v%0d_rdata", i), rdata, vecs[i].exp_rdata);
            check($sformatf("v%0d_ram_cycles", i), 64'(rc), 64'(vecs[i].exp_ram_cycles));
            check($sformatf("v%0d_write_cycle", i), 64'(wl), 64'(vecs[i].exp_wr_lat));
            if (vecs[i].exp_wr_lat != 0) begin
                check($sformatf("v%0d_write_addr", i), 64'(wa), 64'(vecs[i].addr >> 3));
                check($sformatf("v%0d_write_data", i), wdq, vecs[i].exp_quad);
            end
            if (vecs[i].chk_idx >= 0)
                check($sformatf("v%0d_mem", i), mem[vecs[i].chk_idx], vecs[i].exp_quad);
            @(negedge clk);
        end

        // Reset pulsed during WT of a byte store 0x77 at 0x0002.
        we_snap   = we_cnt;
        resp_snap = resp_cnt;
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = 16'h0002;
        bus.req_type  = RAM_BYTE;
        bus.req_wdata = 64'h77;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);              // cycle T+2: FSM in WT
        rst = 1'b1;
        #1;
        check("abort_req_ready",  64'(bus.req_ready),  64'd1);
        check("abort_resp_valid", 64'(bus.resp_valid), 64'd0);
        check("abort_resp_rdata", bus.resp_rdata,      64'd0);
        check("abort_ram_en",     64'(ram_en),         64'd0);
        check("abort_ram_we",     64'(ram_we),         64'd0);
        check("abort_ram_addr",   64'(ram_addr),       64'd0);
        check("abort_ram_wdata",  ram_wdata,           64'd0);
        repeat (2) @(negedge clk);
        check("abort_held_req_ready", 64'(bus.req_ready), 64'd1);
        rst = 1'b0;
        check("abort_no_write", 64'(we_cnt),   64'(we_snap));
        check("abort_no_resp",  64'(resp_cnt), 64'(resp_snap));
        check("abort_mem",      mem[0],        64'h00AB_2233_4455_665A);
        // Accepted on the first edge after reset release.
        do_req(1'b0, 16'h0002, RAM_BYTE, 64'h0, lat, err, rdata, rc, wl, wa, wdq);
        check("post_reset_latency", 64'(lat), 64'd3);
        check("post_reset_rdata",   rdata,    64'h22);
        @(negedge clk);

        // Back-to-back with req_valid held high.
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = 16'h0004;
        bus.req_type  = RAM_LONG;
        bus.req_wdata = 64'hDEAD_BEEF;
        @(posedge clk);
        @(negedge clk);
        lat = 1;
        bus.req_write = 1'b0;
        bus.req_wdata = 64'h0;
        check("b2b_ready_low_after_accept", 64'(bus.req_ready), 64'd0);
        while (!bus.resp_valid && lat < 12) begin
            @(negedge clk);
            lat++;
        end
        check("b2b_store_latency", 64'(lat), 64'd4);
        @(negedge clk);
        check("b2b_ready_after_resp", 64'(bus.req_ready), 64'd1);
        @(posedge clk);
        lat = 0;
        rdata = '0;
        while (lat < 12) begin
            @(negedge clk);
            bus.req_valid = 1'b0;
            lat++;
            if (bus.resp_valid) begin
                rdata = bus.resp_rdata;
                break;
            end
        end
        check("b2b_load_latency", 64'(lat), 64'd3);
        check("b2b_load_rdata",   rdata,    64'hDEAD_BEEF);
        check("b2b_mem",          mem[0],   64'h00AB_2233_DEAD_BEEF);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_subquad_ctrl.md
# ram_subquad_ctrl

Sequences all sub-quad (byte/word/long) and quad accesses from a single requester onto the 64-bit quad-wide RAM port. Loads are returned zero-extended into the low bits. Sub-quad stores are done as read-modify-write on the containing quad. The block sits between the loader/CPU memory stage and the quad RAM, and is the only master of the RAM port.

## Interface
Parameters:
- ADDR_WIDTH, 16, byte address width; RAM quad index is ADDR_WIDTH-3 bits.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE; transfer when req_valid && req_ready.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_WIDTH  byte address.
- req_type  in  data_type_t  RAM_QUAD / RAM_LONG / RAM_WORD / RAM_BYTE.
- req_wdata  in  64  store value in low bits; bits above the access size are ignored.
- resp_valid  out  1  one-cycle completion pulse; no backpressure.
- resp_err  out  1  valid with resp_valid; 1 = misaligned, no RAM access done.
- resp_rdata  out  64  load value, zero-extended; 0 for stores and errors.
- ram_en  out  1  RAM access this cycle.
- ram_we  out  1  write when ram_en.
- ram_addr  out  ADDR_WIDTH-3  quad index = addr[ADDR_WIDTH-1:3].
- ram_wdata  out  64  write quad.
- ram_rdata  in  64  read quad; valid the cycle after a read-enable cycle.

## Operation
- Memory is big-endian. Let o = addr[2:0]. A byte at offset o occupies bits [63-8o -: 8]. A word occupies [63-8o -: 16]. A long occupies [63-8o -: 32]. A quad occupies all 64 bits.
- Alignment rule: a word needs addr[0]=0, a long needs addr[1:0]=0, a quad needs addr[2:0]=0. A byte is always aligned.
- Request fields are registered on accept. Inputs are not sampled again until the next IDLE.
- States:
  - IDLE: req_ready=1. On accept:
    - misaligned -> RESP with err=1;
    - quad store -> WR;
    - anything else -> RD.
  - RD: ram_en=1, ram_we=0. Go to WT.
  - WT: ram_rdata is valid.
    - Load: register the extracted lane, right-justified and zero-extended, then go to RESP.
    - Sub-quad store: register the merged quad (the read quad with only the target lane replaced by the low bits of req_wdata), then go to WR.
  - WR: ram_en=1, ram_we=1, ram_wdata = merged quad, or req_wdata for a quad store. Go to RESP.
  - RESP: resp_valid=1 with resp_err/resp_rdata. Go to IDLE.
- ram_en, ram_we, ram_addr and ram_wdata are decoded from registered state. ram_addr and ram_wdata are 0 when ram_en=0.
- A quad load uses RD/WT and returns ram_rdata unchanged.

## Timing
- Take the accept edge as cycle T.
- Latency:
  - misaligned: resp_valid at T+1;
  - quad store: ram write at T+1, resp at T+2;
  - load: read at T+1, resp at T+3;
  - sub-quad store: read at T+1, write at T+3, resp at T+4.
- req_ready falls in the cycle after accept and returns in the cycle after resp_valid. Maximum throughput is one request per (latency+1) cycles.
- Reset values: state IDLE, req_ready=1. All other outputs are 0: resp_valid, resp_err, resp_rdata, ram_en, ram_we, ram_addr, ram_wdata.
- Reset mid-operation:
  - The FSM returns to IDLE asynchronously.
  - A pending write that has not reached WR is never issued.
  - No resp_valid is produced for the aborted request.
  - A request is accepted on the first clock edge after rst deasserts.
- Requests presented while req_ready=0 are ignored, not queued.

## Test plan
- Preload quad 0 = 0x0011223344556677.
  - Byte load at 0x0003 -> resp_rdata=0x0000000000000033 at T+3, resp_err=0.
  - Word load at 0x0006 -> 0x6677.
  - Long load at 0x0000 -> 0x00112233.
- Same preload; byte store 0xAB (req_wdata=0xFFFFFFFFFFFFFFAB) at 0x0001.
  - Read at T+1 and write at T+3 of 0x00AB223344556677 to ram_addr 0.
  - resp_valid at T+4.
- Quad store 0x0123456789ABCDEF at 0x0008.
  - Exactly one RAM cycle: ram_we=1, ram_addr=1 at T+1.
  - resp_valid at T+2.
- Misaligned word load at 0x0005 and long store at 0x0002.
  - Each gives resp_valid=1, resp_err=1, resp_rdata=0 at T+1.
  - ram_en stays 0 throughout.
- Sub-quad store with rst pulsed during WT.
  - ram_we is never asserted and no resp_valid appears.
  - All outputs read 0 with req_ready=1 while rst is high.
  - A following load returns the unmodified value.
- Back-to-back with req_valid held high: long store 0xDEADBEEF at 0x0004, then long load at 0x0004.
  - The second request is accepted in the cycle after the first resp_valid.
  - It returns 0xDEADBEEF.
